uart_cmd_dispatcher: RTL and testbench

Consumes decoded UART command frames (code, length, 32-bit parameter list, check byte plus a one-cycle valid pulse) from the UART command decoder. Validates each frame and executes it against the local-dimming configuration register set. Emits a 4-byte ACK/NACK response to the UART transmitter over a valid/ready handshake. Config writes land in shadow registers and reach the dimming datapath only on a video frame boundary (rising edge of vs_in).

---
 rtl/uart_cmd_pkg.sv | 59 +++++
 rtl/cfg_shadow_regs.sv | 78 +++++++
 rtl/uart_cmd_dispatcher.sv | 173 +++++++++++++++++
 tb/tb_uart_cmd_dispatcher.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM encoding and payload types for the UART command dispatcher.
// Build option: CMD_CHECKSUM_EN selects summed check byte instead of a fixed marker.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_MODE   = 8'h01;
    localparam logic [7:0] CMD_GAIN   = 8'h02;
    localparam logic [7:0] CMD_ZONE   = 8'h03;
    localparam logic [7:0] CMD_ENABLE = 8'h04;
    localparam logic [7:0] CMD_STATUS = 8'h05;

    localparam logic [7:0] ERR_OK      = 8'h00;
    localparam logic [7:0] ERR_UNKNOWN = 8'h01;
    localparam logic [7:0] ERR_LEN     = 8'h02;
    localparam logic [7:0] ERR_CHECK   = 8'h03;
    localparam logic [7:0] ERR_RANGE   = 8'h04;

    localparam logic [7:0] FRAME_HEADER = 8'h40;
    localparam logic [7:0] FRAME_TAIL   = 8'hBC;
    localparam logic [7:0] NACK         = 8'hEE;
    localparam logic [7:0] ACK_FLAG     = 8'h80;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_GLOBAL = 2'd1;
    localparam logic [1:0] MODE_LOCAL  = 2'd2;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE, S_CHECK, S_EXEC, S_R_HDR, S_R_CODE, S_R_STAT, S_R_TAIL
    } state_t;

    typedef struct packed {
        logic [7:0]  code;
        logic [7:0]  len;
        logic [31:0] params;
        logic [7:0]  check;
    } cmd_t;

    typedef struct packed {
        logic [1:0]  mode;
        logic [15:0] gain;
        logic [7:0]  zone_x;
        logic [7:0]  zone_y;
        logic        dim_en;
    } cfg_t;

    // Expected frame length per command; zero marks an unknown code.
    function automatic logic [7:0] cmd_len(input logic [7:0] code);
        case (code)
            CMD_MODE:   return 8'd2;
            CMD_GAIN:   return 8'd3;
            CMD_ZONE:   return 8'd3;
            CMD_ENABLE: return 8'd2;
            CMD_STATUS: return 8'd1;
            default:    return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/cfg_shadow_regs.sv
// Shadow/active configuration pairs; shadow is promoted to active on a vsync rising edge.
module cfg_shadow_regs
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  DEF_ZONE_X = 8'd8,
    parameter logic [7:0]  DEF_ZONE_Y = 8'd8,
    parameter logic [15:0] DEF_GAIN   = 16'h0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs_in,
    input  logic        wr_en,
    input  logic [7:0]  wr_code,
    input  logic [15:0] wr_data,
    output logic [1:0]  shadow_mode,
    output logic        shadow_dim_en,
    output logic        pending,
    output logic        cfg_update,
    output logic [1:0]  mode,
    output logic [15:0] gain,
    output logic [7:0]  zone_x,
    output logic [7:0]  zone_y,
    output logic        dim_en
);

    localparam cfg_t CFG_RESET = '{mode: MODE_GLOBAL, gain: DEF_GAIN, zone_x: DEF_ZONE_X,
                                   zone_y: DEF_ZONE_Y, dim_en: 1'b0};

    cfg_t shadow_q, shadow_d, active_q;
    logic vs_q;
    logic vs_rise;

    assign vs_rise = vs_in & ~vs_q;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            case (wr_code)
                CMD_MODE:   shadow_d.mode   = wr_data[1:0];
                CMD_GAIN:   shadow_d.gain   = wr_data;
                CMD_ZONE: begin
                    shadow_d.zone_x = wr_data[7:0];
                    shadow_d.zone_y = wr_data[15:8];
                end
                CMD_ENABLE: shadow_d.dim_en = wr_data[0];
                default: ;
            endcase
        end
    end

    // Active copies the pre-write shadow; a simultaneous write keeps pending set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= CFG_RESET;
            active_q   <= CFG_RESET;
            pending    <= 1'b0;
            cfg_update <= 1'b0;
            vs_q       <= 1'b0;
        end else begin
            vs_q       <= vs_in;
            shadow_q   <= shadow_d;
            cfg_update <= vs_rise & pending;
            pending    <= wr_en | (pending & ~vs_rise);
            if (vs_rise && pending) begin
                active_q <= shadow_q;
            end
        end
    end

    assign shadow_mode   = shadow_q.mode;
    assign shadow_dim_en = shadow_q.dim_en;
    assign mode          = active_q.mode;
    assign gain          = active_q.gain;
    assign zone_x        = active_q.zone_x;
    assign zone_y        = active_q.zone_y;
    assign dim_en        = active_q.dim_en;

endmodule

// File: rtl/uart_cmd_dispatcher.sv
// Validates decoded UART command frames, updates dimming config and returns a 4-byte ACK/NACK.
// Build option: CMD_CHECKSUM_EN (check byte = len + code + param bytes, else fixed 8'hBC).
module uart_cmd_dispatcher
    import uart_cmd_pkg::*;
#(
    parameter int unsigned MAX_ZONE_X = 16,
    parameter int unsigned MAX_ZONE_Y = 16,
    parameter int unsigned DEF_ZONE_X = 8,
    parameter int unsigned DEF_ZONE_Y = 8,
    parameter logic [15:0] DEF_GAIN   = 16'h0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cmd_valid,
    input  logic [7:0]  i_cmdcode,
    input  logic [7:0]  i_cmd_len,
    input  logic [31:0] i_para_list,
    input  logic [7:0]  i_check,
    input  logic        vs_in,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [1:0]  o_mode,
    output logic [15:0] o_gain,
    output logic [7:0]  o_zone_x,
    output logic [7:0]  o_zone_y,
    output logic        o_dim_en,
    output logic        o_cfg_update,
    output logic [7:0]  o_drop_cnt,
    output logic        o_busy
);

    localparam logic [7:0] MAX_X    = 8'(MAX_ZONE_X);
    localparam logic [7:0] MAX_Y    = 8'(MAX_ZONE_Y);
    localparam logic [7:0] DROP_MAX = 8'hFF;

    state_t     state_q, state_d;
    cmd_t       cmd_q;
    logic [7:0] err_q, err_c, stat_q, check_ref, exp_len, b0, b1;
    logic [7:0] tx_data_d, drop_q;
    logic       tx_valid_d, busy_q, wr_en;
    logic [1:0] shadow_mode;
    logic       shadow_dim_en, pending;

    assign b0      = cmd_q.params[7:0];
    assign b1      = cmd_q.params[15:8];
    assign exp_len = cmd_len(cmd_q.code);

`ifdef CMD_CHECKSUM_EN
    // Sum covers len, code and the len-1 parameter bytes actually carried.
    always_comb begin
        check_ref = cmd_q.len + cmd_q.code;
        for (int i = 0; i < 4; i++) begin
            if (32'(i) + 32'd1 < 32'(cmd_q.len)) begin
                check_ref = check_ref + cmd_q.params[8*i +: 8];
            end
        end
    end
`else
    logic unused_params;
    assign check_ref     = FRAME_TAIL;
    assign unused_params = ^cmd_q.params[31:16];
`endif

    always_comb begin
        err_c = ERR_OK;
        if (cmd_q.check != check_ref) begin
            err_c = ERR_CHECK;
        end else if (exp_len == 8'd0) begin
            err_c = ERR_UNKNOWN;
        end else if (cmd_q.len != exp_len) begin
            err_c = ERR_LEN;
        end else if ((cmd_q.code == CMD_MODE && b0[1:0] == 2'd3) ||
                     (cmd_q.code == CMD_ZONE &&
                      (b0 == 8'd0 || b0 > MAX_X || b1 == 8'd0 || b1 > MAX_Y))) begin
            err_c = ERR_RANGE;
        end
    end

    assign wr_en = (state_q == S_EXEC) && (err_q == ERR_OK) && (cmd_q.code != CMD_STATUS);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (i_cmd_valid) state_d = S_CHECK;
            S_CHECK:  state_d = S_EXEC;
            S_EXEC:   state_d = S_R_HDR;
            S_R_HDR:  if (i_tx_ready) state_d = S_R_CODE;
            S_R_CODE: if (i_tx_ready) state_d = S_R_STAT;
            S_R_STAT: if (i_tx_ready) state_d = S_R_TAIL;
            S_R_TAIL: if (i_tx_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Response byte for the upcoming state, registered so it holds through a stall.
    always_comb begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        case (state_d)
            S_R_HDR:  begin tx_valid_d = 1'b1; tx_data_d = FRAME_HEADER; end
            S_R_CODE: begin
                tx_valid_d = 1'b1;
                tx_data_d  = (err_q == ERR_OK) ? (cmd_q.code | ACK_FLAG) : NACK;
            end
            S_R_STAT: begin tx_valid_d = 1'b1; tx_data_d = stat_q; end
            S_R_TAIL: begin tx_valid_d = 1'b1; tx_data_d = FRAME_TAIL; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            err_q      <= ERR_OK;
            stat_q     <= 8'h00;
            o_tx_valid <= 1'b0;
            o_tx_data  <= 8'h00;
            busy_q     <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            o_tx_valid <= tx_valid_d;
            o_tx_data  <= tx_data_d;
            busy_q     <= (state_d != S_IDLE);
            if (state_q == S_IDLE && i_cmd_valid) begin
                cmd_q <= '{code: i_cmdcode, len: i_cmd_len, params: i_para_list, check: i_check};
            end
            if (state_q == S_CHECK) begin
                err_q <= err_c;
            end
            if (state_q == S_EXEC) begin
                if (err_q != ERR_OK) begin
                    stat_q <= err_q;
                end else if (cmd_q.code == CMD_STATUS) begin
                    stat_q <= {shadow_dim_en, shadow_mode, pending, (drop_q != 8'h00), 3'b000};
                end else begin
                    stat_q <= 8'h00;
                end
            end
            if (i_cmd_valid && busy_q && drop_q != DROP_MAX) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    cfg_shadow_regs #(
        .DEF_ZONE_X (8'(DEF_ZONE_X)),
        .DEF_ZONE_Y (8'(DEF_ZONE_Y)),
        .DEF_GAIN   (DEF_GAIN)
    ) u_cfg (
        .clk           (clk),
        .rst_n         (rst_n),
        .vs_in         (vs_in),
        .wr_en         (wr_en),
        .wr_code       (cmd_q.code),
        .wr_data       (cmd_q.params[15:0]),
        .shadow_mode   (shadow_mode),
        .shadow_dim_en (shadow_dim_en),
        .pending       (pending),
        .cfg_update    (o_cfg_update),
        .mode          (o_mode),
        .gain          (o_gain),
        .zone_x        (o_zone_x),
        .zone_y        (o_zone_y),
        .dim_en        (o_dim_en)
    );

    assign o_drop_cnt = drop_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Scoreboard bench for uart_cmd_dispatcher: directed cases plus randomized commands vs a reference model.
module tb_uart_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic [7:0]  i_cmdcode = 8'h00;
    logic [7:0]  i_cmd_len = 8'h00;
    logic [31:0] i_para_list = 32'h0;
    logic [7:0]  i_check = 8'h00;
    logic        vs_in = 1'b0;
    logic        i_tx_ready = 1'b1;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic [1:0]  o_mode;
    logic [15:0] o_gain;
    logic [7:0]  o_zone_x, o_zone_y;
    logic        o_dim_en, o_cfg_update, o_busy;
    logic [7:0]  o_drop_cnt;

    always #5 clk = ~clk;

    uart_cmd_dispatcher dut (
        .clk(clk), .rst_n(rst_n), .i_cmd_valid(i_cmd_valid), .i_cmdcode(i_cmdcode),
        .i_cmd_len(i_cmd_len), .i_para_list(i_para_list), .i_check(i_check), .vs_in(vs_in),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_mode(o_mode), .o_gain(o_gain), .o_zone_x(o_zone_x), .o_zone_y(o_zone_y),
        .o_dim_en(o_dim_en), .o_cfg_update(o_cfg_update), .o_drop_cnt(o_drop_cnt), .o_busy(o_busy)
    );

    int errors = 0;
    int checks = 0;
    int upd_seen = 0;
    int exp_upd = 0;
    logic rdy_rand = 1'b0;
    logic [7:0] exp_q[$];

    // Reference state: shadow (s_*), active (a_*), pending flag and drop counter.
    logic [1:0]  s_mode, a_mode;
    logic [15:0] s_gain, a_gain;
    logic [7:0]  s_zx, s_zy, a_zx, a_zy, m_drop;
    logic        s_en, a_en, m_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] good_check(input logic [7:0] code, input logic [7:0] len,
                                              input logic [31:0] p);
        logic [7:0] s;
        s = len + code;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(len) - 1) s = s + p[8*i +: 8];
        end
`ifdef CMD_CHECKSUM_EN
        return s;
`else
        return 8'hBC;
`endif
    endfunction

    function automatic logic [7:0] std_len(input logic [7:0] code);
        case (code)
            8'h01, 8'h04: return 8'd2;
            8'h02, 8'h03: return 8'd3;
            8'h05:        return 8'd1;
            default:      return 8'd2;
        endcase
    endfunction

    task automatic model_reset();
        s_mode = 2'd1; s_gain = 16'h0100; s_zx = 8'd8; s_zy = 8'd8; s_en = 1'b0;
        a_mode = 2'd1; a_gain = 16'h0100; a_zx = 8'd8; a_zy = 8'd8; a_en = 1'b0;
        m_pend = 1'b0; m_drop = 8'd0;
        exp_q.delete();
    endtask

    task automatic model_vs();
        if (m_pend) begin
            a_mode = s_mode; a_gain = s_gain; a_zx = s_zx; a_zy = s_zy; a_en = s_en;
            m_pend = 1'b0;
            exp_upd++;
        end
    endtask

    task automatic model_drop();
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    endtask

    // Applies a command to the model and queues its 4 expected response bytes.
    task automatic expect_cmd(input logic [7:0] code, input logic [7:0] len,
                              input logic [31:0] p, input logic [7:0] chk);
        logic [7:0] b0, b1, err, st;
        b0 = p[7:0]; b1 = p[15:8];
        err = 8'h00;
        if (chk != good_check(code, len, p)) err = 8'h03;
        else begin
            case (code)
                8'h01: err = (len != 8'd2) ? 8'h02 : ((b0[1:0] == 2'd3) ? 8'h04 : 8'h00);
                8'h02: err = (len != 8'd3) ? 8'h02 : 8'h00;
                8'h03: err = (len != 8'd3) ? 8'h02 :
                             ((b0 == 0 || b0 > 16 || b1 == 0 || b1 > 16) ? 8'h04 : 8'h00);
                8'h04: err = (len != 8'd2) ? 8'h02 : 8'h00;
                8'h05: err = (len != 8'd1) ? 8'h02 : 8'h00;
                default: err = 8'h01;
            endcase
        end
        st = err;
        if (err == 8'h00) begin
            st = 8'h00;
            case (code)
                8'h01: s_mode = b0[1:0];
                8'h02: s_gain = {b1, b0};
                8'h03: begin s_zx = b0; s_zy = b1; end
                8'h04: s_en = b0[0];
                default: st = {s_en, s_mode, m_pend, (m_drop != 8'd0), 3'b000};
            endcase
            if (code != 8'h05) m_pend = 1'b1;
        end
        exp_q.push_back(8'h40);
        exp_q.push_back((err == 8'h00) ? (code | 8'h80) : 8'hEE);
        exp_q.push_back(st);
        exp_q.push_back(8'hBC);
    endtask

    task automatic send(input logic [7:0] code, input logic [7:0] len,
                        input logic [31:0] p, input logic [7:0] chk);
        @(posedge clk); #1;
        i_cmd_valid = 1'b1; i_cmdcode = code; i_cmd_len = len; i_para_list = p; i_check = chk;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
        end
    endtask

    task automatic run_cmd(input logic [7:0] code, input logic [7:0] len, input logic [31:0] p,
                           input logic [7:0] chk);
        expect_cmd(code, len, p, chk);
        send(code, len, p, chk);
        wait_idle();
    endtask

    task automatic check_active();
        check("mode", 32'(o_mode), 32'(a_mode));
        check("gain", 32'(o_gain), 32'(a_gain));
        check("zone_x", 32'(o_zone_x), 32'(a_zx));
        check("zone_y", 32'(o_zone_y), 32'(a_zy));
        check("dim_en", 32'(o_dim_en), 32'(a_en));
    endtask

    task automatic vs_pulse();
        @(posedge clk); #1 vs_in = 1'b1;
        model_vs();
        @(posedge clk); #1 vs_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_active();
        check("cfg_update_count", 32'(upd_seen), 32'(exp_upd));
    endtask

    task automatic check_reset_outputs();
        check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check("rst_tx_data", 32'(o_tx_data), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
        check("rst_cfg_update", 32'(o_cfg_update), 32'd0);
        check_active();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on each accepted byte and checks hold during stalls.
    initial begin
        logic       stall_prev;
        logic [7:0] data_prev, e;
        stall_prev = 1'b0;
        data_prev  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_prev && o_tx_valid) check("tx_data_hold", 32'(o_tx_data), 32'(data_prev));
                if (o_tx_valid && i_tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tx_byte_unexpected: got 0x%0h expected no byte", o_tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", 32'(o_tx_data), 32'(e));
                    end
                end
                if (o_cfg_update) upd_seen++;
                stall_prev = o_tx_valid && !i_tx_ready;
                data_prev  = o_tx_data;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) i_tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel, n;
        logic [7:0]  code, len, chk;
        logic [31:0] p;

        do_reset();

        // GAIN lands in shadow only; active follows on the next vsync.
        run_cmd(8'h02, 8'd3, 32'h0000_0280, good_check(8'h02, 8'd3, 32'h0000_0280));
        check("gain_before_vs", 32'(o_gain), 32'h0100);
        vs_pulse();
        check("gain_after_vs", 32'(o_gain), 32'h0280);

        // Range, check, code and length errors.
        run_cmd(8'h03, 8'd3, 32'h0000_0400, good_check(8'h03, 8'd3, 32'h0000_0400));
        run_cmd(8'h03, 8'd3, 32'h0000_0411, good_check(8'h03, 8'd3, 32'h0000_0411));
        run_cmd(8'h01, 8'd2, 32'h0000_0002, good_check(8'h01, 8'd2, 32'h2) ^ 8'h5A);
        run_cmd(8'h09, 8'd2, 32'h0000_0001, good_check(8'h09, 8'd2, 32'h1));
        run_cmd(8'h01, 8'd3, 32'h0000_0001, good_check(8'h01, 8'd3, 32'h1));
        vs_pulse();

        // Stall mid-response while two commands arrive and are dropped.
        i_tx_ready = 1'b0;
        expect_cmd(8'h01, 8'd2, 32'h0, good_check(8'h01, 8'd2, 32'h0));
        send(8'h01, 8'd2, 32'h0, good_check(8'h01, 8'd2, 32'h0));
        n = 0;
        while (!o_tx_valid && n < 50) begin @(negedge clk); n++; end
        check("stall_tx_valid_seen", 32'(o_tx_valid), 32'd1);
        @(posedge clk); #1 i_tx_ready = 1'b1;
        @(posedge clk); #1 i_tx_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            i_cmd_valid = (k == 4 || k == 11);
            i_cmdcode   = 8'h02;
            if (k == 4 || k == 11) model_drop();
        end
        i_cmd_valid = 1'b0;
        i_tx_ready  = 1'b1;
        wait_idle();
        check("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
        vs_pulse();

        // ENABLE written in the same cycle as a vsync rise with a prior write pending.
        run_cmd(8'h02, 8'd3, 32'h0000_0123, good_check(8'h02, 8'd3, 32'h123));
        chk = good_check(8'h04, 8'd2, 32'h1);
        model_vs();
        expect_cmd(8'h04, 8'd2, 32'h1, chk);
        @(posedge clk); #1;
        i_cmd_valid = 1'b1; i_cmdcode = 8'h04; i_cmd_len = 8'd2; i_para_list = 32'h1; i_check = chk;
        @(posedge clk); #1 i_cmd_valid = 1'b0;
        @(posedge clk); #1 vs_in = 1'b1;
        @(posedge clk); #1 vs_in = 1'b0;
        wait_idle();
        #1;
        check("dim_en_same_cycle", 32'(o_dim_en), 32'd0);
        check_active();
        vs_pulse();
        check("dim_en_next_vs", 32'(o_dim_en), 32'd1);

        // Randomized commands with random back-pressure.
        rdy_rand = 1'b1;
        for (int t = 0; t < 60; t++) begin
            sel  = $urandom_range(0, 6);
            code = (sel < 5) ? 8'(sel + 1) : 8'($urandom_range(6, 255));
            len  = ($urandom_range(0, 4) != 0) ? std_len(code) : 8'($urandom_range(0, 6));
            p    = $urandom;
            if (code == 8'h03) begin
                p[7:0]  = 8'($urandom_range(0, 18));
                p[15:8] = 8'($urandom_range(0, 18));
            end
            chk = good_check(code, len, p);
            if ($urandom_range(0, 6) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            run_cmd(code, len, p, chk);
            if ($urandom_range(0, 3) == 0) vs_pulse();
        end
        rdy_rand = 1'b0;
        @(posedge clk); #1 i_tx_ready = 1'b1;

        // STATUS after MODE=2 without vsync, then reset in the middle of a response.
        do_reset();
        run_cmd(8'h01, 8'd2, 32'h2, good_check(8'h01, 8'd2, 32'h2));
        run_cmd(8'h05, 8'd1, 32'h0, good_check(8'h05, 8'd1, 32'h0));
        i_tx_ready = 1'b0;
        expect_cmd(8'h05, 8'd1, 32'h0, good_check(8'h05, 8'd1, 32'h0));
        send(8'h05, 8'd1, 32'h0, good_check(8'h05, 8'd1, 32'h0));
        n = 0;
        while (!o_tx_valid && n < 50) begin @(negedge clk); n++; end
        check("mid_tx_valid_seen", 32'(o_tx_valid), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check("mid_rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        i_tx_ready = 1'b1;
        do_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
